// File: rtl/seg_status_arb_pkg.sv
// Shared definitions for the 7-segment status arbiter: display codes, code width, FSM encoding.
// The optional blink feature is enabled by defining SEG_STATUS_BLINK_EN.
package seg_status_arb_pkg;

  localparam int SEG_DIGITS = 3;
  localparam int W          = 4 * SEG_DIGITS;

  // Status codes the boot/status producers place on their src_code lanes.
  localparam logic [W-1:0] STATE_CALIB = 12'hCA1;
  localparam logic [W-1:0] STATE_CLEAR = 12'hC1E;
  localparam logic [W-1:0] STATE_LOAD  = 12'h10A;
  localparam logic [W-1:0] STATE_ERR   = 12'hEEE;

  typedef enum logic {
    SHOW_DEFAULT = 1'b0,
    SHOW_SRC     = 1'b1
  } disp_state_e;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg_status_arb_if.sv
// Bundle between status producers (master) and the display arbiter (slave).
// Optional blink output behaviour depends on SEG_STATUS_BLINK_EN in the arbiter.
interface seg_status_arb_if
  import seg_status_arb_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int CODE_W  = W
);
  localparam int IDX_W = clog2_min1(NUM_SRC);

  // src_valid is a level request with no ready/backpressure: a source holds it high for as
  // long as it wants to be shown, and the arbiter samples it on every rising clk edge.
  logic [NUM_SRC-1:0]        src_valid;
  logic [NUM_SRC*CODE_W-1:0] src_code;
  logic [CODE_W-1:0]         default_code;
  logic                      clear_sticky;

  logic [CODE_W-1:0]  seg_digits;
  logic [IDX_W-1:0]   sel_idx;
  logic               sel_default;
  logic [NUM_SRC-1:0] sticky_flags;
  logic               seg_blank;
  disp_state_e        dbg_state;

  modport master (
    output src_valid, src_code, default_code, clear_sticky,
    input  seg_digits, sel_idx, sel_default, sticky_flags, seg_blank, dbg_state
  );

  modport slave (
    input  src_valid, src_code, default_code, clear_sticky,
    output seg_digits, sel_idx, sel_default, sticky_flags, seg_blank, dbg_state
  );

endinterface

// File: rtl/seg_status_arb_prio_enc.sv
// Combinational fixed-priority encoder: lowest set index wins, plus an any-request flag.
// Independent of SEG_STATUS_BLINK_EN.
module seg_prio_enc
  import seg_status_arb_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int IDX_W   = clog2_min1(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] i_req,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_idx = IDX_W'(i);
        o_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg_status_arb.sv
// Registered priority arbiter choosing the 7-segment status code, with sticky errors and hold time.
// Define SEG_STATUS_BLINK_EN to build the blink counter that flashes latched errors on seg_blank.
module seg_status_arb
  import seg_status_arb_pkg::*;
#(
  parameter int                   NUM_SRC     = 4,
  parameter int                   DIGITS      = 3,
  parameter int                   HOLD_CYCLES = 1024,
  parameter logic [NUM_SRC-1:0]   STICKY_MASK = 4'b0010,
  parameter logic [4*DIGITS-1:0]  RESET_CODE  = '0
`ifdef SEG_STATUS_BLINK_EN
  ,
  parameter int                   BLINK_LOG2  = 24
`endif
) (
  input logic            clk,
  input logic            rst_n,
  seg_status_arb_if.slave bus
);

  localparam int CODE_W = 4 * DIGITS;
  localparam int IDX_W  = clog2_min1(NUM_SRC);
  localparam int HOLD_W = clog2_min1(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES);

  disp_state_e        r_state;
  logic [IDX_W-1:0]   r_sel_idx;
  logic [HOLD_W-1:0]  r_hold;
  logic [NUM_SRC-1:0] r_sticky;
  logic [CODE_W-1:0]  r_digits;

  disp_state_e        w_state_d;
  logic [IDX_W-1:0]   w_sel_d;
  logic [HOLD_W-1:0]  w_hold_d;
  logic [NUM_SRC-1:0] w_sticky_d;
  logic [CODE_W-1:0]  w_digits_d;
  logic [NUM_SRC-1:0] w_eff;
  logic [IDX_W-1:0]   w_win;
  logic               w_any;
  logic               w_preempt;
  logic               w_expire;

  seg_prio_enc #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (IDX_W)
  ) u_prio_enc (
    .i_req (w_eff),
    .o_idx (w_win),
    .o_any (w_any)
  );

  always_comb begin
    w_eff      = bus.src_valid | r_sticky;
    // A set in the same cycle as a clear must survive, so the set term is ORed last.
    w_sticky_d = (r_sticky & ~{NUM_SRC{bus.clear_sticky}}) | (bus.src_valid & STICKY_MASK);

    w_preempt  = w_any && ((r_state == SHOW_DEFAULT) || (w_win < r_sel_idx));
    w_expire   = (r_hold == '0) &&
                 (w_any ? (w_win != r_sel_idx) : (r_state == SHOW_SRC));

    w_state_d  = r_state;
    w_sel_d    = r_sel_idx;
    w_hold_d   = r_hold;
    if (w_preempt || w_expire) begin
      w_state_d = w_any ? SHOW_SRC : SHOW_DEFAULT;
      w_sel_d   = w_any ? w_win : '0;
      w_hold_d  = HOLD_LOAD;
    end else if (r_hold != '0) begin
      w_hold_d  = r_hold - HOLD_W'(1);
    end

    // A selected source that dropped its request keeps its last code until reselection.
    if (w_state_d == SHOW_DEFAULT) begin
      w_digits_d = bus.default_code;
    end else if (w_eff[w_sel_d]) begin
      w_digits_d = bus.src_code[w_sel_d*CODE_W +: CODE_W];
    end else begin
      w_digits_d = r_digits;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= SHOW_DEFAULT;
      r_sel_idx <= '0;
      r_hold    <= '0;
      r_sticky  <= '0;
      r_digits  <= RESET_CODE;
    end else begin
      r_state   <= w_state_d;
      r_sel_idx <= w_sel_d;
      r_hold    <= w_hold_d;
      r_sticky  <= w_sticky_d;
      r_digits  <= w_digits_d;
    end
  end

  assign bus.seg_digits   = r_digits;
  assign bus.sel_idx      = r_sel_idx;
  assign bus.sel_default  = (r_state == SHOW_DEFAULT);
  assign bus.sticky_flags = r_sticky;
  assign bus.dbg_state    = r_state;

`ifdef SEG_STATUS_BLINK_EN
  logic [BLINK_LOG2:0] r_blink_cnt;
  logic                r_blank;

  // Blank is computed from next-cycle selection/sticky so it lines up with the other outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blink_cnt <= '0;
      r_blank     <= 1'b0;
    end else begin
      r_blink_cnt <= r_blink_cnt + (BLINK_LOG2 + 1)'(1);
      r_blank     <= r_blink_cnt[BLINK_LOG2] & (w_state_d == SHOW_SRC) & w_sticky_d[w_sel_d];
    end
  end

  assign bus.seg_blank = r_blank;
`else
  assign bus.seg_blank = 1'b0;
`endif

endmodule

// File: tb/tb_seg_status_arb.sv
// Directed bench for seg_status_arb with a spec-level reference model checked every cycle.
// Default build; SEG_STATUS_BLINK_EN also switches on the blink part of the model.
module tb_seg_status_arb;
  import seg_status_arb_pkg::*;

  localparam int          N_SRC = 4;
  localparam int          CW    = 12;
  localparam int          HOLD  = 4;
  localparam logic [3:0]  MASK  = 4'b0010;
`ifdef SEG_STATUS_BLINK_EN
  localparam int          TB_BLINK_LOG2 = 2;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  int n_checks = 0;
  int n_errors = 0;

  seg_status_arb_if #(.NUM_SRC(N_SRC), .CODE_W(CW)) bus ();

  seg_status_arb #(
    .NUM_SRC     (N_SRC),
    .DIGITS      (3),
    .HOLD_CYCLES (HOLD),
    .STICKY_MASK (MASK),
    .RESET_CODE  (12'h000)
`ifdef SEG_STATUS_BLINK_EN
    ,
    .BLINK_LOG2  (TB_BLINK_LOG2)
`endif
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    bit          dflt;
    int          idx;
    int          hold;
    logic [3:0]  sticky;
    logic [11:0] digits;
    bit          blank;
    int          cnt;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r.dflt = 1'b1; r.idx = 0; r.hold = 0; r.sticky = 4'b0;
    r.digits = 12'h000; r.blank = 1'b0; r.cnt = 0;
    return r;
  endfunction

  function automatic model_t model_next(input model_t cur, input logic [3:0] v,
                                        input logic [47:0] codes, input logic [11:0] dc,
                                        input logic clr);
    model_t     n;
    int         win;
    int         shown;
    logic [3:0] eff;
    n     = cur;
    win   = -1;
    eff   = v | cur.sticky;
    shown = cur.dflt ? -1 : cur.idx;
    for (int i = 3; i >= 0; i--) if (eff[i]) win = i;
    if (win >= 0 && (cur.dflt || win < cur.idx)) begin
      n.dflt = 1'b0; n.idx = win; n.hold = HOLD;
    end else if (cur.hold == 0 && win != shown) begin
      n.dflt = (win < 0); n.idx = (win < 0) ? 0 : win; n.hold = HOLD;
    end else if (cur.hold > 0) begin
      n.hold = cur.hold - 1;
    end
    if (n.dflt) n.digits = dc;
    else if (eff[n.idx]) n.digits = codes[n.idx*12 +: 12];
    n.sticky = (cur.sticky & ~{4{clr}}) | (v & MASK);
`ifdef SEG_STATUS_BLINK_EN
    n.cnt   = cur.cnt + 1;
    n.blank = (((cur.cnt >> TB_BLINK_LOG2) & 1) == 1) && !n.dflt && n.sticky[n.idx];
`endif
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= model_reset();
    else m <= model_next(m, bus.src_valid, bus.src_code, bus.default_code, bus.clear_sticky);
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("cmp_digits", 32'(bus.seg_digits), 32'(m.digits));
    check("cmp_sel_idx", 32'(bus.sel_idx), m.idx);
    check("cmp_sel_default", 32'(bus.sel_default), 32'(m.dflt));
    check("cmp_sticky", 32'(bus.sticky_flags), 32'(m.sticky));
    check("cmp_blank", 32'(bus.seg_blank), 32'(m.blank));
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_code(input int idx, input logic [11:0] val);
    bus.src_code[idx*12 +: 12] = val;
  endtask

  task automatic expect_out(input string name, input logic [11:0] digits, input int idx,
                            input logic dflt);
    check({name, "_digits"}, 32'(bus.seg_digits), 32'(digits));
    check({name, "_idx"}, 32'(bus.sel_idx), idx);
    check({name, "_dflt"}, 32'(bus.sel_default), 32'(dflt));
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    bus.src_valid    = '0;
    bus.src_code     = '0;
    bus.default_code = 12'h0A5;
    bus.clear_sticky = 1'b0;
    #1 rst_n = 1'b0;
    #7;
    expect_out("reset", 12'h000, 0, 1'b1);
    check("reset_sticky", 32'(bus.sticky_flags), 32'h0);
    #4 rst_n = 1'b1;
    tick();
    expect_out("idle_default", 12'h0A5, 0, 1'b1);
    bus.default_code = 12'h0B7;
    tick();
    expect_out("default_live", 12'h0B7, 0, 1'b1);
    bus.default_code = 12'h0A5;

    // source 3 shown, then source 0 preempts without waiting for hold
    bus.src_valid = 4'b1000; set_code(3, 12'hC42);
    tick();
    expect_out("show_src3", 12'hC42, 3, 1'b0);
    set_code(0, 12'hE01); bus.src_valid = 4'b1001;
    tick();
    expect_out("preempt_src0", 12'hE01, 0, 1'b0);
    bus.src_valid = 4'b0000;
    repeat (4) tick();
    expect_out("src0_frozen", 12'hE01, 0, 1'b0);
    tick();
    expect_out("src0_expired", 12'h0A5, 0, 1'b1);

    // single-cycle pulse on source 3 is held HOLD+1 cycles, frozen
    bus.src_valid = 4'b1000;
    tick();
    expect_out("pulse3", 12'hC42, 3, 1'b0);
    bus.src_valid = 4'b0000; set_code(3, 12'hC99);
    repeat (4) tick();
    expect_out("pulse3_frozen", 12'hC42, 3, 1'b0);
    tick();
    expect_out("pulse3_revert", 12'h0A5, 0, 1'b1);

    // sticky source 1
    set_code(1, 12'hEEE); bus.src_valid = 4'b0010;
    tick();
    expect_out("sticky_show", 12'hEEE, 1, 1'b0);
    check("sticky_set", 32'(bus.sticky_flags), 32'h2);
    bus.src_valid = 4'b0000;
    repeat (8) tick();
    expect_out("sticky_kept", 12'hEEE, 1, 1'b0);
    bus.clear_sticky = 1'b1; bus.src_valid = 4'b0010;
    tick();
    bus.clear_sticky = 1'b0; bus.src_valid = 4'b0000;
    tick();
    check("set_beats_clear", 32'(bus.sticky_flags), 32'h2);
    bus.clear_sticky = 1'b1;
    tick();
    bus.clear_sticky = 1'b0;
    check("sticky_cleared", 32'(bus.sticky_flags), 32'h0);
    expect_out("clear_cycle", 12'hEEE, 1, 1'b0);
    tick();
    expect_out("after_clear", 12'h0A5, 0, 1'b1);

    // live code tracking on source 3
    set_code(3, 12'hC00); bus.src_valid = 4'b1000;
    tick();
    expect_out("live_start", 12'hC00, 3, 1'b0);
    for (int k = 1; k < 256; k++) begin
      set_code(3, 12'hC00 + 12'(k));
      tick();
      check("live_track", 32'(bus.seg_digits), 32'h0C00 + 32'(k));
    end

    // source 2 preempts, drops, and hold blocks the lower-priority source 3
    set_code(2, 12'hA22); bus.src_valid = 4'b0100;
    tick();
    expect_out("preempt_src2", 12'hA22, 2, 1'b0);
    bus.src_valid = 4'b1000;
    repeat (4) tick();
    expect_out("hold_blocks_3", 12'hA22, 2, 1'b0);
    tick();
    expect_out("hold_expired_3", 12'hCFF, 3, 1'b0);

    // asynchronous reset in the middle of a hold
    set_code(0, 12'hE01); bus.src_valid = 4'b0011;
    tick();
    expect_out("pre_reset", 12'hE01, 0, 1'b0);
    check("pre_reset_sticky", 32'(bus.sticky_flags), 32'h2);
    bus.src_valid = 4'b0000;
    tick();
    #2 rst_n = 1'b0;
    #1;
    expect_out("async_reset", 12'h000, 0, 1'b1);
    check("async_reset_sticky", 32'(bus.sticky_flags), 32'h0);
    #3 rst_n = 1'b1;
    tick();
    expect_out("post_reset", 12'h0A5, 0, 1'b1);
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
